// File: rtl/dffrs_pipe_pkg.sv
// Shared constants for the dffrs_pipe elastic register pipeline.
// Scan chain ordering and async set/reset priority live here.
package dffrs_pkg;

  localparam bit PRIO_RN_OVER_SN = 1'b1;
  localparam bit SCAN_VALID_AFTER_DATA = 1'b1;

  function automatic int scan_len(input int width, input int depth);
    return width * depth + depth;
  endfunction

endpackage

// File: rtl/dffrs_pipe_if.sv
// Handshake and data bundle between upstream/downstream and dffrs_pipe.
interface dffrs_pipe_if #(
  parameter int WIDTH = 8
);
  logic             VLD_IN;
  logic             RDY_OUT;
  logic [WIDTH-1:0] D;
  logic             VLD_OUT;
  logic             EN;
  logic [WIDTH-1:0] Q;
  logic [WIDTH-1:0] QN;

  modport master (output VLD_IN, D, EN, input RDY_OUT, VLD_OUT, Q, QN);
  modport slave  (input VLD_IN, D, EN, output RDY_OUT, VLD_OUT, Q, QN);
endinterface

// File: rtl/dffrs_pipe_stage.sv
// One pipeline stage: valid + data with async RN/SN, load enables and scan mux.
module dffrs_pipe_stage
  import dffrs_pkg::*;
#(
  parameter int               WIDTH     = 8,
  parameter logic [WIDTH-1:0] RESET_VAL = '0,
  parameter logic [WIDTH-1:0] SET_VAL   = '1
) (
  input  logic             CK,
  input  logic             RN,
  input  logic             SN,
  input  logic             upd,
  input  logic             v_src,
  input  logic             ld,
  input  logic [WIDTH-1:0] d_src,
  input  logic             scan_en,
  input  logic             scan_v,
  input  logic [WIDTH-1:0] scan_d,
  output logic             v,
  output logic [WIDTH-1:0] d
);

  typedef struct packed {
    logic             v;
    logic [WIDTH-1:0] d;
  } stage_t;

  localparam stage_t ST_RST = '{v: 1'b0, d: RESET_VAL};
  localparam stage_t ST_SET = '{v: 1'b0, d: SET_VAL};

  stage_t st, st_nxt;

  // Data only moves with a valid source so empty stages keep their last word.
  always_comb begin
    st_nxt = st;
    if (scan_en) begin
      st_nxt.v = scan_v;
      st_nxt.d = scan_d;
    end else begin
      if (upd) st_nxt.v = v_src;
      if (ld)  st_nxt.d = d_src;
    end
  end

  generate
    if (PRIO_RN_OVER_SN) begin : g_rn_first
      always_ff @(posedge CK or negedge RN or negedge SN) begin
        if (!RN)      st <= ST_RST;
        else if (!SN) st <= ST_SET;
        else          st <= st_nxt;
      end
    end else begin : g_sn_first
      always_ff @(posedge CK or negedge RN or negedge SN) begin
        if (!SN)      st <= ST_SET;
        else if (!RN) st <= ST_RST;
        else          st <= st_nxt;
      end
    end
  endgenerate

  assign v = st.v;
  assign d = st.d;

endmodule

// File: rtl/dffrs_pipe.sv
// DEPTH-stage elastic register pipeline with bubble collapse and async RN/SN.
// Optional scan chain through all data then valid bits: define DFFRS_PIPE_SCAN_EN.
module dffrs_pipe
  import dffrs_pkg::*;
#(
  parameter int               WIDTH     = 8,
  parameter int               DEPTH     = 2,
  parameter logic [WIDTH-1:0] RESET_VAL = '0,
  parameter logic [WIDTH-1:0] SET_VAL   = '1
) (
  input  logic        CK,
  input  logic        RN,
  input  logic        SN,
`ifdef DFFRS_PIPE_SCAN_EN
  input  logic        SE,
  input  logic        SI,
  output logic        SO,
`endif
  dffrs_pipe_if.slave bus
);

  logic [DEPTH-1:0] v, adv, upd, ld, vsrc, scan_v;
  logic [WIDTH-1:0] d      [DEPTH];
  logic [WIDTH-1:0] dsrc   [DEPTH];
  logic [WIDTH-1:0] scan_d [DEPTH];
  logic             scan_en;
  logic             rdy;

  // Advance ripples back from the output; RDY_OUT is combinational from EN.
  always_comb begin
    logic a;
    adv  = '0;
    upd  = '0;
    ld   = '0;
    vsrc = '0;
    a = v[DEPTH-1] & bus.EN;
    adv[DEPTH-1] = a;
    for (int i = DEPTH - 2; i >= 0; i--) begin
      a = v[i] & (~v[i+1] | a);
      adv[i] = a;
    end
    rdy     = ~scan_en & (~v[0] | adv[0]);
    upd[0]  = rdy;
    vsrc[0] = bus.VLD_IN;
    ld[0]   = bus.VLD_IN & rdy;
    for (int i = 1; i < DEPTH; i++) begin
      upd[i]  = ~v[i] | adv[i];
      vsrc[i] = v[i-1];
      ld[i]   = (~v[i] | adv[i]) & v[i-1];
    end
  end

  for (genvar i = 0; i < DEPTH; i++) begin : g_stage
    if (i == 0) begin : g_src0
      assign dsrc[i] = bus.D;
    end else begin : g_srcn
      assign dsrc[i] = d[i-1];
    end

    dffrs_pipe_stage #(
      .WIDTH    (WIDTH),
      .RESET_VAL(RESET_VAL),
      .SET_VAL  (SET_VAL)
    ) u_stage (
      .CK     (CK),
      .RN     (RN),
      .SN     (SN),
      .upd    (upd[i]),
      .v_src  (vsrc[i]),
      .ld     (ld[i]),
      .d_src  (dsrc[i]),
      .scan_en(scan_en),
      .scan_v (scan_v[i]),
      .scan_d (scan_d[i]),
      .v      (v[i]),
      .d      (d[i])
    );
  end

`ifdef DFFRS_PIPE_SCAN_EN
  localparam int CHAIN_LEN = scan_len(WIDTH, DEPTH);
  localparam int DBASE = SCAN_VALID_AFTER_DATA ? 0 : DEPTH;
  localparam int VBASE = SCAN_VALID_AFTER_DATA ? DEPTH * WIDTH : 0;

  logic [CHAIN_LEN-1:0] chain, shifted;

  // SI enters d[0][0]; the last bit of the chain drives SO.
  always_comb begin
    chain  = '0;
    scan_v = '0;
    for (int i = 0; i < DEPTH; i++) begin
      scan_d[i] = '0;
      for (int b = 0; b < WIDTH; b++) chain[DBASE + i*WIDTH + b] = d[i][b];
      chain[VBASE + i] = v[i];
    end
    shifted = {chain[CHAIN_LEN-2:0], SI};
    for (int i = 0; i < DEPTH; i++) begin
      for (int b = 0; b < WIDTH; b++) scan_d[i][b] = shifted[DBASE + i*WIDTH + b];
      scan_v[i] = shifted[VBASE + i];
    end
  end

  assign scan_en = SE;
  assign SO      = chain[CHAIN_LEN-1];
`else
  assign scan_en = 1'b0;
  assign scan_v  = v;
  for (genvar i = 0; i < DEPTH; i++) begin : g_noscan
    assign scan_d[i] = d[i];
  end
`endif

  assign bus.RDY_OUT = rdy;
  assign bus.VLD_OUT = v[DEPTH-1];
  assign bus.Q       = d[DEPTH-1];
  assign bus.QN      = (!RN && !SN) ? '0 : ~d[DEPTH-1];

endmodule

// File: tb/tb_dffrs_pipe.sv
// Scoreboard bench for dffrs_pipe: model tracks words in flight as a queue.
module tb_dffrs_pipe;
  localparam int W   = 8;
  localparam int DEP = 3;

  logic ck = 1'b0;
  logic rn, sn;
  always #5 ck = ~ck;

  dffrs_pipe_if #(.WIDTH(W)) bus ();

`ifdef DFFRS_PIPE_SCAN_EN
  logic se, si, so;
  logic se2, si2, so2;
  dffrs_pipe_if #(.WIDTH(4)) bus2 ();
  dffrs_pipe #(.WIDTH(4), .DEPTH(2)) dut_s (
    .CK(ck), .RN(rn), .SN(sn), .SE(se2), .SI(si2), .SO(so2), .bus(bus2.slave));
`endif

  dffrs_pipe #(.WIDTH(W), .DEPTH(DEP)) dut (
    .CK (ck),
    .RN (rn),
    .SN (sn),
`ifdef DFFRS_PIPE_SCAN_EN
    .SE (se),
    .SI (si),
    .SO (so),
`endif
    .bus(bus.slave)
  );

  int checks = 0;
  int errors = 0;
  int outs   = 0;
  logic [W-1:0] sb[$];
  bit sb_on    = 1'b0;
  bit acc_flag = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  // Ready holds unless the pipe is full with the output stalled.
  always @(negedge ck) begin
    if (sb_on && rn === 1'b1 && sn === 1'b1) begin
      logic er;
      er = (sb.size() < DEP) || bus.EN;
      chk("rdy_out", bus.RDY_OUT, er);
      acc_flag = bus.VLD_IN && er;
      if (acc_flag) sb.push_back(bus.D);
    end else begin
      acc_flag = 1'b0;
    end
  end

  always @(negedge ck) begin
    if (sb_on && rn === 1'b1 && sn === 1'b1 && bus.VLD_OUT === 1'b1 && bus.EN) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_out actual=%0h required=none", bus.Q);
      end else begin
        logic [W-1:0] e, ne;
        e  = sb.pop_front();
        ne = ~e;
        chk("q_data", bus.Q, e);
        chk("qn_data", bus.QN, ne);
        outs++;
      end
    end
  end

  task automatic step();
    @(posedge ck);
    #2;
  endtask

  task automatic send(input logic [W-1:0] val, input logic en);
    bus.VLD_IN = 1'b1;
    bus.D      = val;
    bus.EN     = en;
    for (int n = 0; n < 50; n++) begin
      step();
      if (acc_flag) return;
    end
    checks++;
    errors++;
    $display("FAIL send_timeout actual=none required=%0h", val);
  endtask

  task automatic drain();
    bus.VLD_IN = 1'b0;
    bus.EN     = 1'b1;
    for (int n = 0; n < 50; n++) begin
      if (sb.size() == 0) break;
      step();
    end
    step();
    chk("drain_empty", sb.size(), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int o0;
    rn = 1'b0; sn = 1'b1;
    bus.VLD_IN = 1'b0; bus.EN = 1'b0; bus.D = '0;
`ifdef DFFRS_PIPE_SCAN_EN
    se = 1'b0; si = 1'b0; se2 = 1'b0; si2 = 1'b0;
    bus2.VLD_IN = 1'b0; bus2.EN = 1'b0; bus2.D = '0;
`endif
    #3;
    chk("rst_q", bus.Q, 8'h00);
    chk("rst_vld", bus.VLD_OUT, 1'b0);
    chk("rst_rdy", bus.RDY_OUT, 1'b1);
    chk("rst_qn", bus.QN, 8'hFF);
    sn = 1'b0;
    #1;
    chk("rst_both_qn", bus.QN, 8'h00);
    chk("rst_both_q", bus.Q, 8'h00);
    step(); step();
    rn = 1'b1; sn = 1'b1;
    sb_on = 1'b1;

    // first word latency
    bus.D = 8'hA5; bus.VLD_IN = 1'b1; bus.EN = 1'b1;
    step();
    bus.VLD_IN = 1'b0;
    repeat (DEP - 1) step();
    chk("lat_q", bus.Q, 8'hA5);
    chk("lat_vld", bus.VLD_OUT, 1'b1);
    drain();

    // async set with two words in flight
    send(8'($urandom), 1'b0);
    send(8'($urandom), 1'b0);
    bus.VLD_IN = 1'b0;
    step();
    sn = 1'b0;
    #1;
    chk("set_q", bus.Q, 8'hFF);
    chk("set_qn", bus.QN, 8'h00);
    chk("set_vld", bus.VLD_OUT, 1'b0);
    chk("set_rdy", bus.RDY_OUT, 1'b1);
    sb.delete();
    step();
    sn = 1'b1;
    send(8'h3C, 1'b1);
    bus.VLD_IN = 1'b0;
    for (int n = 0; n < 10; n++) begin
      if (bus.VLD_OUT === 1'b1) break;
      step();
    end
    chk("set_next_vld", bus.VLD_OUT, 1'b1);
    chk("set_next_q", bus.Q, 8'h3C);
    drain();

    // backpressure
    o0 = outs;
    send(8'h01, 1'b0);
    send(8'h02, 1'b0);
    send(8'h03, 1'b0);
    bus.D = 8'h04;
    chk("bp_rdy_low", bus.RDY_OUT, 1'b0);
    repeat (3) step();
    send(8'h04, 1'b1);
    drain();
    chk("bp_count", outs - o0, 4);

    // bubble collapse
    send(8'h10, 1'b0);
    bus.VLD_IN = 1'b0;
    step();
    send(8'h20, 1'b0);
    bus.VLD_IN = 1'b0;
    repeat (3) step();
    chk("bub_q", bus.Q, 8'h10);
    chk("bub_vld", bus.VLD_OUT, 1'b1);
    chk("bub_rdy", bus.RDY_OUT, 1'b1);
    bus.EN = 1'b1;
    step();
    chk("bub_q2", bus.Q, 8'h20);
    chk("bub_vld2", bus.VLD_OUT, 1'b1);
    drain();

    // full throughput
    o0 = outs;
    bus.VLD_IN = 1'b1; bus.EN = 1'b1; bus.D = 8'($urandom);
    for (int i = 0; i <= 100 + DEP; i++) begin
      step();
      if (i < 99) bus.D = 8'($urandom);
      else        bus.VLD_IN = 1'b0;
      chk("thr_vld", bus.VLD_OUT, (i >= DEP - 1) && (i <= 98 + DEP));
    end
    chk("thr_count", outs - o0, 100);
    drain();

    // random traffic
    for (int i = 0; i < 300; i++) begin
      bus.VLD_IN = 1'($urandom_range(0, 1));
      bus.EN     = ($urandom_range(0, 3) != 0);
      bus.D      = 8'($urandom);
      step();
    end
    drain();

    // reset mid-transfer
    send(8'($urandom), 1'b0);
    send(8'($urandom), 1'b0);
    rn = 1'b0;
    #1;
    chk("mr_q", bus.Q, 8'h00);
    chk("mr_vld", bus.VLD_OUT, 1'b0);
    chk("mr_rdy", bus.RDY_OUT, 1'b1);
    sb.delete();
    step();
    rn = 1'b1;
    bus.VLD_IN = 1'b0; bus.EN = 1'b1;
    repeat (5) begin
      step();
      chk("mr_no_out", bus.VLD_OUT, 1'b0);
    end

`ifdef DFFRS_PIPE_SCAN_EN
    begin
      logic [9:0] pat;
      pat = 10'b1011001110;
      sb_on = 1'b0;
      se2 = 1'b1;
      for (int k = 0; k < 10; k++) begin
        si2 = pat[9-k];
        step();
      end
      chk("scan_rdy", bus2.RDY_OUT, 1'b0);
      for (int k = 0; k < 10; k++) begin
        chk("scan_so", so2, pat[9-k]);
        si2 = 1'b0;
        step();
      end
      si2 = 1'b1;
      repeat (5) step();
      rn = 1'b0;
      #1;
      chk("scan_rst_so", so2, 1'b0);
      step();
      rn = 1'b1;
      for (int k = 0; k < 10; k++) begin
        chk("scan_clr", so2, 1'b0);
        step();
      end
      se2 = 1'b0;
    end
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
